// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - multi-channel timer with FREE/PWM/ONESHOT modes
// Optional terminal-count flags enabled by defining MULTI_TIMER_IRQ_EN.
module multi_timer #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 1,
    localparam int AW      = $clog2(CHANNELS) + 2
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic [AW-1:0]       rd_addr,
    output logic [WIDTH-1:0]    rd_data,
    output logic [CHANNELS-1:0] tc_oc,
    output logic [CHANNELS-1:0] tc_int
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        MODE_FREE    = 2'd0,
        MODE_PWM     = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    logic [PW-1:0]       pre_q, pre_d;
    logic                tick;
    logic [CHANNELS-1:0] en_q, en_d;
    logic [CHANNELS-1:0] oc_q, oc_d;
    mode_e               mode_q [CHANNELS];
    mode_e               mode_d [CHANNELS];
    logic [WIDTH-1:0]    top_q  [CHANNELS];
    logic [WIDTH-1:0]    top_d  [CHANNELS];
    logic [WIDTH-1:0]    cmp_q  [CHANNELS];
    logic [WIDTH-1:0]    cmp_d  [CHANNELS];
    logic [WIDTH-1:0]    cnt_q  [CHANNELS];
    logic [WIDTH-1:0]    cnt_d  [CHANNELS];
    logic [WIDTH-1:0]    nxt_cnt[CHANNELS];
    logic [CHANNELS-1:0] term;
    logic [CHANNELS-1:0] term_ev;
    logic [CHANNELS-1:0] int_clr;
    logic [WIDTH-1:0]    rd_data_q, rd_data_d;
    logic [AW-1:0]       wr_ch, rd_ch;

    assign wr_ch = wr_addr >> 2;
    assign rd_ch = rd_addr >> 2;

    assign tick  = (pre_q == PW'(PRESCALE - 1));
    assign pre_d = tick ? '0 : pre_q + 1'b1;

    // ">=" rather than "==" so a TOP written below cnt still wraps on the next tick
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            term[i]    = (cnt_q[i] >= top_q[i]);
            nxt_cnt[i] = term[i] ? '0 : cnt_q[i] + 1'b1;
        end
    end

    always_comb begin
        en_d    = en_q;
        oc_d    = oc_q;
        mode_d  = mode_q;
        top_d   = top_q;
        cmp_d   = cmp_q;
        cnt_d   = cnt_q;
        term_ev = '0;
        int_clr = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (tick && en_q[i]) begin
                case (mode_q[i])
                    MODE_FREE: begin
                        cnt_d[i]   = nxt_cnt[i];
                        term_ev[i] = term[i];
                        if (cnt_q[i] == cmp_q[i]) oc_d[i] = ~oc_q[i];
                    end
                    MODE_PWM: begin
                        cnt_d[i]   = nxt_cnt[i];
                        term_ev[i] = term[i];
                        oc_d[i]    = (nxt_cnt[i] < cmp_q[i]);
                    end
                    MODE_ONESHOT: begin
                        cnt_d[i]   = nxt_cnt[i];
                        term_ev[i] = term[i];
                        oc_d[i]    = ~term[i];
                        if (term[i]) en_d[i] = 1'b0;
                    end
                    default: oc_d[i] = 1'b0;
                endcase
            end
            // Register writes land after the tick update so they override it
            if (wr_en && (wr_ch == AW'(i))) begin
                case (wr_addr[1:0])
                    2'd0: begin
                        en_d[i]    = wr_data[0];
                        mode_d[i]  = mode_e'(wr_data[2:1]);
                        int_clr[i] = wr_data[7];
                        if (mode_e'(wr_data[2:1]) != mode_q[i]) begin
                            cnt_d[i] = '0;
                            oc_d[i]  = 1'b0;
                        end
                    end
                    2'd1:    top_d[i] = wr_data;
                    2'd2:    cmp_d[i] = wr_data;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_ch == AW'(i)) begin
                case (rd_addr[1:0])
                    2'd0:    rd_data_d = WIDTH'({mode_d[i], en_d[i]});
                    2'd1:    rd_data_d = top_d[i];
                    2'd2:    rd_data_d = cmp_d[i];
                    default: rd_data_d = cnt_d[i];
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pre_q     <= '0;
            en_q      <= '0;
            oc_q      <= '0;
            mode_q    <= '{default: MODE_FREE};
            top_q     <= '{default: '0};
            cmp_q     <= '{default: '0};
            cnt_q     <= '{default: '0};
            rd_data_q <= '0;
        end else begin
            pre_q     <= pre_d;
            en_q      <= en_d;
            oc_q      <= oc_d;
            mode_q    <= mode_d;
            top_q     <= top_d;
            cmp_q     <= cmp_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign tc_oc   = oc_q;

`ifdef MULTI_TIMER_IRQ_EN
    logic [CHANNELS-1:0] int_q, int_d;
    logic                unused_bits;

    assign int_d = term_ev | (int_q & ~int_clr);

    always_ff @(posedge CLK) begin
        if (RESET) int_q <= '0;
        else       int_q <= int_d;
    end

    assign tc_int      = int_q;
    assign unused_bits = ^wr_data[WIDTH-1:3];
`else
    logic unused_bits;

    assign tc_int      = '0;
    assign unused_bits = ^{wr_data[WIDTH-1:3], term_ev, int_clr};
`endif

endmodule

// File: tb/tb_multi_timer.sv
// tb/tb_multi_timer.sv - scoreboard bench for multi_timer
module tb_multi_timer;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        a_reset, a_wr_en;
    logic [3:0]  a_wr_addr, a_rd_addr;
    logic [15:0] a_wr_data, a_rd_data;
    logic [3:0]  a_tc_oc, a_tc_int;

    logic        b_reset, b_wr_en;
    logic [3:0]  b_wr_addr, b_rd_addr;
    logic [15:0] b_wr_data, b_rd_data;
    logic [2:0]  b_tc_oc, b_tc_int;

    multi_timer #(.CHANNELS(4), .WIDTH(16), .PRESCALE(1)) dut_a (
        .CLK(CLK), .RESET(a_reset), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
        .wr_data(a_wr_data), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .tc_oc(a_tc_oc), .tc_int(a_tc_int)
    );

    multi_timer #(.CHANNELS(3), .WIDTH(16), .PRESCALE(4)) dut_b (
        .CLK(CLK), .RESET(b_reset), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
        .wr_data(b_wr_data), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .tc_oc(b_tc_oc), .tc_int(b_tc_int)
    );

`ifdef MULTI_TIMER_IRQ_EN
    localparam logic [15:0] IRQ_BIT2 = 16'h0004;
`else
    localparam logic [15:0] IRQ_BIT2 = 16'h0000;
`endif

    typedef struct {
        string       tag;
        int          which;
        logic [15:0] exp;
        logic [15:0] mask;
    } exp_t;

    exp_t        sb[$];
    exp_t        sb_item;
    logic [15:0] sb_got;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int which, input logic [15:0] exp,
                        input logic [15:0] mask);
        sb.push_back('{tag, which, exp, mask});
    endtask

    always @(negedge CLK) begin
        while (sb.size() > 0) begin
            sb_item = sb.pop_front();
            case (sb_item.which)
                0:       sb_got = a_rd_data;
                1:       sb_got = {12'b0, a_tc_oc};
                2:       sb_got = {12'b0, a_tc_int};
                default: sb_got = b_rd_data;
            endcase
            check_eq(sb_item.tag, sb_got & sb_item.mask, sb_item.exp & sb_item.mask);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
        a_wr_en = 1'b0;
        b_wr_en = 1'b0;
    endtask

    task automatic set_a(input logic [3:0] addr, input logic [15:0] data);
        a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data;
    endtask

    task automatic set_b(input logic [3:0] addr, input logic [15:0] data);
        b_wr_en = 1'b1; b_wr_addr = addr; b_wr_data = data;
    endtask

    task automatic wr_a(input logic [3:0] addr, input logic [15:0] data);
        set_a(addr, data);
        step();
    endtask

    initial begin
        a_reset = 1'b1; a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_rd_addr = 4'd3;
        b_reset = 1'b1; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_rd_addr = 4'd3;
        step();
        step();
        push("rst_rd",   0, 16'h0, 16'hFFFF);
        push("rst_oc",   1, 16'h0, 16'hFFFF);
        push("rst_int",  2, 16'h0, 16'hFFFF);
        push("rst_b_rd", 3, 16'h0, 16'hFFFF);
        a_reset = 1'b0;
        b_reset = 1'b0;

        // FREE: ch0 TOP=4 CMP=2
        wr_a(4'd1, 16'd4);
        wr_a(4'd2, 16'd2);
        wr_a(4'd0, 16'd1);
        push("free_cnt", 0, 16'd0, 16'hFFFF);
        push("free_oc",  1, 16'd0, 16'hFFFF);
        for (int k = 1; k <= 10; k++) begin
            step();
            push("free_cnt", 0, 16'(k % 5), 16'hFFFF);
            push("free_oc",  1, 16'(((k + 2) / 5) % 2), 16'hFFFF);
        end
        wr_a(4'd0, 16'd0);
        push("hold_cnt", 0, 16'd1, 16'hFFFF);
        step();
        step();
        push("hold_cnt", 0, 16'd1, 16'hFFFF);
        push("hold_oc",  1, 16'd0, 16'hFFFF);

        // Mode change FREE->PWM on ch3 at cnt=7
        a_rd_addr = 4'd15;
        wr_a(4'd13, 16'd20);
        wr_a(4'd14, 16'd5);
        wr_a(4'd12, 16'd1);
        for (int k = 1; k <= 9; k++) begin
            if (k == 8) set_a(4'd12, 16'd3);
            step();
            push("mode_cnt", 0, 16'((k <= 7) ? k : k - 8), 16'hFFFF);
            push("mode_oc",  1, (((k >= 6) && (k <= 7)) || (k == 9)) ? 16'h8 : 16'h0, 16'hFFFF);
        end

        // Reset mid-count
        a_reset = 1'b1;
        step();
        a_reset = 1'b0;
        push("midrst_rd",  0, 16'h0, 16'hFFFF);
        push("midrst_oc",  1, 16'h0, 16'hFFFF);
        push("midrst_int", 2, 16'h0, 16'hFFFF);
        step();
        push("midrst_cnt", 0, 16'h0, 16'hFFFF);

        // PWM: ch1 TOP=9 CMP=3, then CMP=0, then CMP=12
        a_rd_addr = 4'd7;
        wr_a(4'd5, 16'd9);
        wr_a(4'd6, 16'd3);
        wr_a(4'd4, 16'd3);
        for (int k = 1; k <= 42; k++) begin
            if (k == 21) set_a(4'd6, 16'd0);
            if (k == 32) set_a(4'd6, 16'd12);
            step();
            push("pwm_cnt", 0, 16'(k % 10), 16'hFFFF);
            if (k <= 21)      push("pwm_oc",      1, ((k % 10) < 3) ? 16'h2 : 16'h0, 16'hFFFF);
            else if (k <= 32) push("pwm_oc_cmp0", 1, 16'h0, 16'hFFFF);
            else              push("pwm_oc_cmp12", 1, 16'h2, 16'hFFFF);
        end
        wr_a(4'd4, 16'd2);

        // ONESHOT: ch2 TOP=5
        a_rd_addr = 4'd11;
        wr_a(4'd9, 16'd5);
        wr_a(4'd8, 16'd5);
        for (int k = 1; k <= 9; k++) begin
            step();
            push("os_cnt", 0, 16'((k <= 5) ? k : 0), 16'hFFFF);
            push("os_oc",  1, (k <= 5) ? 16'h6 : 16'h2, 16'hFFFF);
            push("os_int", 2, (k >= 6) ? IRQ_BIT2 : 16'h0, 16'h0004);
        end
        a_rd_addr = 4'd8;
        step();
        push("os_ctrl", 0, 16'd4, 16'hFFFF);
        wr_a(4'd8, 16'h0084);
        push("intclr",      2, 16'h0, 16'h0004);
        push("intclr_ctrl", 0, 16'd4, 16'hFFFF);
        wr_a(4'd9, 16'd0);
        wr_a(4'd8, 16'd5);
        push("os2_int",  2, 16'h0, 16'h0004);
        push("os2_ctrl", 0, 16'd5, 16'hFFFF);
        wr_a(4'd8, 16'h0084);
        push("set_vs_clr",      2, IRQ_BIT2, 16'h0004);
        push("set_vs_clr_ctrl", 0, 16'd4, 16'hFFFF);
        push("set_vs_clr_oc",   1, 16'h2, 16'hFFFF);

        // PRESCALE=4 on dut_b: TOP=2, then TOP=0 while cnt=2
        b_reset = 1'b1;
        step();
        b_reset = 1'b0;
        b_rd_addr = 4'd3;
        for (int n = 1; n <= 30; n++) begin
            if (n == 1)  set_b(4'd1, 16'd2);
            if (n == 2)  set_b(4'd0, 16'd1);
            if (n == 21) set_b(4'd1, 16'd0);
            step();
            push("pre_cnt", 3, 16'((n >= 24) ? 0 : (n / 4) % 3), 16'hFFFF);
        end

        // Out-of-range channel on dut_b (CHANNELS=3)
        set_b(4'd13, 16'h0055);
        b_rd_addr = 4'd13;
        step();
        push("oor_rd13", 3, 16'h0, 16'hFFFF);
        b_rd_addr = 4'd1;
        step();
        push("oor_top0", 3, 16'h0, 16'hFFFF);
        b_rd_addr = 4'd0;
        step();
        push("oor_ctrl0", 3, 16'h1, 16'hFFFF);

        step();
        step();
        check_eq("sb_drain", 16'(sb.size()), 16'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
